// File: rtl/avalon_timer_pkg.sv
// Shared register map and bit positions for the Avalon interval timer.
package avalon_timer_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_down_counter.sv
// Reloadable down-counter: decrements while running, reloads on zero or on a forced reload.
module timer_down_counter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             force_reload,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             is_zero
);

  logic [WIDTH-1:0] counter_q, counter_d;

  assign counter = counter_q;
  assign is_zero = (counter_q == '0);

  // Next count: forced reload beats counting; zero wraps back to the period.
  always_comb begin
    counter_d = counter_q;
    if (force_reload)
      counter_d = load_value;
    else if (run)
      counter_d = is_zero ? load_value : counter_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) counter_q <= RESET_VALUE;
    else          counter_q <= counter_d;
  end

endmodule

// File: rtl/avalon_interval_timer.sv
// Avalon-MM interval timer: programmable period, one-shot/continuous, snapshot, level irq.
module avalon_interval_timer
  import avalon_timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH  = 32,
  parameter logic [31:0] RESET_PERIOD   = 32'd49999,
  parameter bit          START_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam logic [COUNTER_WIDTH-1:0] RST_PERIOD = RESET_PERIOD[COUNTER_WIDTH-1:0];

  logic [COUNTER_WIDTH-1:0] period_q, period_d;
  logic [COUNTER_WIDTH-1:0] snap_q, snap_d;
  logic [COUNTER_WIDTH-1:0] counter;
  logic                     is_zero;
  logic                     run_q, run_d;
  logic                     to_q, to_d;
  logic                     ito_q, ito_d;
  logic                     cont_q, cont_d;
  logic                     force_reload_q, force_reload_d;
  logic [15:0]              readdata_q, readdata_d;

  logic wr, wr_status, wr_control, wr_period, timeout;

  assign wr         = chipselect && !write_n;
  assign wr_status  = wr && (address == ADDR_STATUS);
  assign wr_control = wr && (address == ADDR_CONTROL);
  assign wr_period  = wr && ((address == ADDR_PERIODL) || (address == ADDR_PERIODH));
  assign timeout    = run_q && is_zero;

  assign irq      = to_q && ito_q;
  assign readdata = readdata_q;

  timer_down_counter #(
    .WIDTH       (COUNTER_WIDTH),
    .RESET_VALUE (RST_PERIOD)
  ) u_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run_q),
    .force_reload (force_reload_q),
    .load_value   (period_q),
    .counter      (counter),
    .is_zero      (is_zero)
  );

  // Register writes and RUN/TO arbitration; later assignments take priority.
  always_comb begin
    period_d       = period_q;
    snap_d         = snap_q;
    run_d          = run_q;
    to_d           = to_q;
    ito_d          = ito_q;
    cont_d         = cont_q;
    force_reload_d = wr_period;

    if (timeout && !cont_q) run_d = 1'b0;

    if (wr_control) begin
      ito_d  = writedata[CTRL_ITO];
      cont_d = writedata[CTRL_CONT];
      if (writedata[CTRL_START]) run_d = 1'b1;
      if (writedata[CTRL_STOP])  run_d = 1'b0;
    end

    if (wr && address == ADDR_PERIODL) period_d[15:0] = writedata;
    if (wr && address == ADDR_PERIODH) period_d[COUNTER_WIDTH-1:16] = writedata[COUNTER_WIDTH-17:0];
    if (wr_period) run_d = 1'b0;

    if (wr && (address == ADDR_SNAPL || address == ADDR_SNAPH)) snap_d = counter;

    // A timeout on the same edge as a clear must not be lost.
    if (wr_status) to_d = 1'b0;
    if (timeout)   to_d = 1'b1;
  end

  // Read mux, sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STAT_TO]  = to_q;
        readdata_d[STAT_RUN] = run_q;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_ITO]  = ito_q;
        readdata_d[CTRL_CONT] = cont_q;
      end
      ADDR_PERIODL: readdata_d = period_q[15:0];
      ADDR_PERIODH: readdata_d = 16'(period_q >> 16);
      ADDR_SNAPL:   readdata_d = snap_q[15:0];
      ADDR_SNAPH:   readdata_d = 16'(snap_q >> 16);
      default:      readdata_d = '0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q       <= RST_PERIOD;
      snap_q         <= '0;
      run_q          <= START_ON_RESET;
      cont_q         <= START_ON_RESET;
      to_q           <= 1'b0;
      ito_q          <= 1'b0;
      force_reload_q <= 1'b0;
      readdata_q     <= '0;
    end else begin
      period_q       <= period_d;
      snap_q         <= snap_d;
      run_q          <= run_d;
      cont_q         <= cont_d;
      to_q           <= to_d;
      ito_q          <= ito_d;
      force_reload_q <= force_reload_d;
      readdata_q     <= readdata_d;
    end
  end

endmodule
